// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM state encoding and
// requester selection.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE_I = 3'd1,
    ST_ISSUE_D = 3'd2,
    ST_WAIT_I  = 3'd3,
    ST_WAIT_D  = 3'd4,
    ST_DUMP    = 3'd5,
    ST_HALTED  = 3'd6
  } state_t;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } src_t;

  function automatic logic is_wait(input state_t st);
    return (st == ST_WAIT_I) || (st == ST_WAIT_D);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Memory-side bus of the arbiter: access strobe/address/data out, busy/done/data back.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_dump;
  logic              mem_busy;
  logic              mem_done;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_en, mem_wr, mem_addr, mem_wdata, mem_dump,
    input  mem_busy, mem_done, mem_rdata
  );

  modport slave (
    input  mem_en, mem_wr, mem_addr, mem_wdata, mem_dump,
    output mem_busy, mem_done, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter_watchdog.sv
// Wait-state watchdog: counts enabled cycles from a clear and flags the
// cycle in which the count reaches TIMEOUT-1.
module arb_watchdog #(
  parameter int TIMEOUT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expire = en && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port multi-cycle memory between fetch (I) and data (D)
// requesters, sequences the halt-time dump and watches for a stuck memory.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int D_STREAK_MAX = 4,
  parameter int TIMEOUT      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  input  logic              dump_req,
  output logic              dump_done,
  mem_arbiter_if.master     mem,
  output logic              err_timeout
);
  localparam int STREAK_W = (D_STREAK_MAX > 0) ? $clog2(D_STREAK_MAX + 1) : 1;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(D_STREAK_MAX);

  function automatic logic [STREAK_W-1:0] streak_next(input logic [STREAK_W-1:0] cur,
                                                      input logic i_waiting);
    if (!i_waiting) return '0;
    if (cur == STREAK_MAX) return cur;
    return cur + STREAK_W'(1);
  endfunction

  state_t              state, state_n;
  logic [STREAK_W-1:0] streak;
  logic                wr_q;
  logic                i_pend, d_pend;
  logic                grant, fin, waiting, wd_expire;
  src_t                grant_src, fin_src;

  // A requester whose done is high this cycle still shows its old req level.
  assign i_pend  = i_req & ~i_done;
  assign d_pend  = d_req & ~d_done;
  assign i_stall = i_req & ~i_done;
  assign d_stall = d_req & ~d_done;
  assign waiting = is_wait(state);

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (!waiting),
    .en     (waiting),
    .expire (wd_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n       = state;
    grant         = 1'b0;
    grant_src     = SRC_I;
    fin           = 1'b0;
    fin_src       = SRC_I;
    mem.mem_en    = 1'b0;
    mem.mem_wr    = 1'b0;
    mem.mem_dump  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dump_req) begin
          state_n = ST_DUMP;
        end else if (!mem.mem_busy) begin
          if (d_pend && !(i_pend && streak == STREAK_MAX)) begin
            grant     = 1'b1;
            grant_src = SRC_D;
            state_n   = ST_ISSUE_D;
          end else if (i_pend) begin
            grant     = 1'b1;
            grant_src = SRC_I;
            state_n   = ST_ISSUE_I;
          end
        end
      end
      ST_ISSUE_I: begin
        mem.mem_en = 1'b1;
        state_n    = ST_WAIT_I;
      end
      ST_ISSUE_D: begin
        mem.mem_en = 1'b1;
        mem.mem_wr = wr_q;
        state_n    = ST_WAIT_D;
      end
      ST_WAIT_I: begin
        if (mem.mem_done || wd_expire) begin
          fin     = 1'b1;
          fin_src = SRC_I;
          state_n = ST_IDLE;
        end
      end
      ST_WAIT_D: begin
        if (mem.mem_done || wd_expire) begin
          fin     = 1'b1;
          fin_src = SRC_D;
          state_n = ST_IDLE;
        end
      end
      ST_DUMP: begin
        mem.mem_dump = 1'b1;
        state_n      = ST_HALTED;
      end
      ST_HALTED: state_n = ST_HALTED;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      streak        <= '0;
      wr_q          <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      i_done        <= 1'b0;
      d_done        <= 1'b0;
      dump_done     <= 1'b0;
      i_rdata       <= '0;
      d_rdata       <= '0;
      err_timeout   <= 1'b0;
    end else begin
      i_done    <= fin && (fin_src == SRC_I);
      d_done    <= fin && (fin_src == SRC_D);
      dump_done <= (state == ST_DUMP);
      if (grant && grant_src == SRC_D) begin
        streak        <= streak_next(streak, i_pend);
        wr_q          <= d_wr;
        mem.mem_addr  <= d_addr;
        mem.mem_wdata <= d_wdata;
      end else if (grant) begin
        streak       <= '0;
        wr_q         <= 1'b0;
        mem.mem_addr <= i_addr;
      end
      // A watchdog completion returns zero data instead of the bus value.
      if (fin && fin_src == SRC_I) begin
        i_rdata <= mem.mem_done ? mem.mem_rdata : '0;
      end
      if (fin && fin_src == SRC_D && !wr_q) begin
        d_rdata <= mem.mem_done ? mem.mem_rdata : '0;
      end
      if (fin && !mem.mem_done) begin
        err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of single transactions plus
// hand-written contention, timeout, reset and dump sequences.
module tb_mem_arbiter;

  logic        clk, rst;
  logic        i_req, i_done, i_stall;
  logic [15:0] i_addr, i_rdata;
  logic        d_req, d_wr, d_done, d_stall;
  logic [15:0] d_addr, d_wdata, d_rdata;
  logic        dump_req, dump_done, err_timeout;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) mif ();

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .D_STREAK_MAX(4), .TIMEOUT(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_done      (i_done),
    .i_rdata     (i_rdata),
    .i_stall     (i_stall),
    .d_req       (d_req),
    .d_wr        (d_wr),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_done      (d_done),
    .d_rdata     (d_rdata),
    .d_stall     (d_stall),
    .dump_req    (dump_req),
    .dump_done   (dump_done),
    .mem         (mif),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Memory model knobs, set by the stimulus process.
  int lat    = 2;
  bit noresp = 1'b0;
  bit recov  = 1'b0;

  logic [15:0] mem_arr [0:255];
  int          cnt = 0;
  logic [7:0]  pa;

  always @(posedge clk) begin
    mif.mem_done <= 1'b0;
    mif.mem_busy <= recov && mif.mem_done;
    if (!rst) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= 16'(i) ^ 16'h5A00;
      mem_arr[8'h40] <= 16'hBEEF;
      mem_arr[8'h20] <= 16'hCAFE;
    end
    if (mif.mem_en === 1'b1) begin
      pa <= mif.mem_addr[7:0];
      if (mif.mem_wr) mem_arr[mif.mem_addr[7:0]] <= mif.mem_wdata;
      if (!noresp) begin
        if (lat <= 1) begin
          mif.mem_done  <= 1'b1;
          mif.mem_rdata <= mem_arr[mif.mem_addr[7:0]];
        end else begin
          cnt <= lat - 1;
        end
      end
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        mif.mem_done  <= 1'b1;
        mif.mem_rdata <= mem_arr[pa];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctrl"}, 32'({i_done, d_done, i_stall, d_stall, dump_done, mif.mem_en,
                             mif.mem_wr, mif.mem_dump, err_timeout}), 32'd0);
    chk({tag, "_rdata"}, {i_rdata, d_rdata}, 32'd0);
    chk({tag, "_membus"}, {mif.mem_addr, mif.mem_wdata}, 32'd0);
  endtask

  typedef struct {
    logic        is_d;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          lat;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t        vecs [6];
  logic [15:0] sb_q [$];
  bit          grant_q [$];

  task automatic run_vec(input int k, input vec_t v);
    int          en_cyc, done_cyc;
    logic [15:0] exp_rd;
    lat = v.lat;
    sb_q.push_back(v.exp_rdata);
    if (v.is_d) begin
      d_req = 1'b1; d_wr = v.wr; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    en_cyc = -1;
    done_cyc = -1;
    for (int c = 1; c <= 100 && done_cyc < 0; c++) begin
      @(posedge clk); #1;
      if (mif.mem_en) begin
        en_cyc = c;
        chk($sformatf("vec%0d_mem_wr", k), 32'(mif.mem_wr), 32'(v.is_d & v.wr));
        chk($sformatf("vec%0d_mem_addr", k), 32'(mif.mem_addr), 32'(v.addr));
        if (v.is_d && v.wr) chk($sformatf("vec%0d_mem_wdata", k), 32'(mif.mem_wdata), 32'(v.wdata));
      end
      if (c == 1) begin
        chk($sformatf("vec%0d_stall_own", k), 32'(v.is_d ? d_stall : i_stall), 32'd1);
        chk($sformatf("vec%0d_stall_other", k), 32'(v.is_d ? i_stall : d_stall), 32'd0);
      end
      if (v.is_d ? d_done : i_done) begin
        done_cyc = c;
        exp_rd = sb_q.pop_front();
        chk($sformatf("vec%0d_rdata", k), 32'(v.is_d ? d_rdata : i_rdata), 32'(exp_rd));
        chk($sformatf("vec%0d_stall_at_done", k), 32'(v.is_d ? d_stall : i_stall), 32'd0);
      end
    end
    chk($sformatf("vec%0d_en_latency", k), en_cyc, 1);
    chk($sformatf("vec%0d_done_latency", k), done_cyc, 2 + v.lat);
    if (done_cyc < 0) sb_q.delete();
    i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL global_time_limit actual=expired required=finish");
    $fatal(1);
  end

  initial begin
    int ngr, nd, idone_cyc, dump_cyc, ddone_cyc, ndump, nen, nstall, en_seen;
    bit fin, i_seen, exp_src;
    vec_t v;

    rst = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_wr = 1'b0;
    d_addr = '0; d_wdata = '0; dump_req = 1'b0;

    vecs[0] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 2, 16'hBEEF};
    vecs[1] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 2, 16'hCAFE};
    vecs[2] = '{1'b1, 1'b1, 16'h0010, 16'h1234, 2, 16'hBEEF};
    vecs[3] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 2, 16'h1234};
    vecs[4] = '{1'b0, 1'b0, 16'h0033, 16'h0000, 1, 16'h5A33};
    vecs[5] = '{1'b1, 1'b0, 16'h0077, 16'h0000, 5, 16'h5A77};

    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset_state");
    rst = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 6; k++) run_vec(k, vecs[k]);

    // Contention: memory is busy for one cycle after each completion.
    recov = 1'b1; lat = 2;
    grant_q = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    i_addr = 16'h0021; d_addr = 16'h0050; d_wr = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    ngr = 0; nd = 0; fin = 1'b0; i_seen = 1'b0;
    for (int c = 1; c <= 300 && !fin; c++) begin
      @(posedge clk); #1;
      if (mif.mem_en) begin
        if (grant_q.size() > 0) begin
          exp_src = grant_q.pop_front();
          chk($sformatf("contention_grant%0d_is_d", ngr), 32'(mif.mem_addr == d_addr), 32'(exp_src));
        end
        ngr++;
      end
      if (i_done) begin
        i_seen = 1'b1;
        chk("contention_d_done_before_i_done", nd, 4);
        chk("contention_i_rdata", 32'(i_rdata), 32'h5A21);
        i_req = 1'b0;
      end
      if (d_done) begin
        nd++;
        if (ngr >= 6) fin = 1'b1;
      end
    end
    chk("contention_i_done_seen", 32'(i_seen), 32'd1);
    chk("contention_grant_count", ngr, 6);
    d_req = 1'b0; i_req = 1'b0; recov = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Memory that never completes an I access.
    noresp = 1'b1;
    i_addr = 16'h0020; i_req = 1'b1;
    idone_cyc = -1;
    for (int c = 1; c <= 60 && idone_cyc < 0; c++) begin
      @(posedge clk); #1;
      if (c == 33) chk("timeout_err_before_expiry", 32'(err_timeout), 32'd0);
      if (i_done) begin
        idone_cyc = c;
        chk("timeout_i_rdata_zero", 32'(i_rdata), 32'd0);
        chk("timeout_err_set", 32'(err_timeout), 32'd1);
      end
    end
    chk("timeout_done_cycle", idone_cyc, 34);
    i_req = 1'b0; noresp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("timeout_err_sticky", 32'(err_timeout), 32'd1);
    v = '{1'b1, 1'b0, 16'h0040, 16'h0000, 2, 16'hBEEF};
    run_vec(6, v);
    chk("timeout_err_still_set", 32'(err_timeout), 32'd1);

    // Reset while waiting on a D read; its completion arrives after release.
    lat = 6;
    d_addr = 16'h0040; d_wr = 1'b0; d_req = 1'b1;
    en_seen = 0;
    for (int c = 1; c <= 10 && en_seen == 0; c++) begin
      @(posedge clk); #1;
      if (mif.mem_en) en_seen = 1;
    end
    chk("rstwait_issue_seen", en_seen, 1);
    @(posedge clk); #1;
    rst = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
    chk_reset("rstwait_reset");
    rst = 1'b1;
    nd = 0; nen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (d_done) nd++;
      if (mif.mem_en) nen++;
    end
    chk("rstwait_no_d_done", nd, 0);
    chk("rstwait_no_mem_en", nen, 0);
    chk("rstwait_d_rdata", 32'(d_rdata), 32'd0);
    v = '{1'b1, 1'b0, 16'h0077, 16'h0000, 2, 16'h5A77};
    run_vec(7, v);

    // All three requests together in IDLE: dump wins.
    i_addr = 16'h0020; d_addr = 16'h0040;
    i_req = 1'b1; d_req = 1'b1; dump_req = 1'b1;
    @(posedge clk); #1;
    chk("dumpall_mem_dump", 32'({mif.mem_dump, mif.mem_en}), 32'b10);
    @(posedge clk); #1;
    chk("dumpall_dump_done", 32'({dump_done, mif.mem_dump}), 32'b10);
    nen = 0; nstall = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (mif.mem_en) nen++;
      if (i_stall && d_stall) nstall++;
    end
    chk("dumpall_halted_no_grant", nen, 0);
    chk("dumpall_halted_stalls", nstall, 5);
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0; dump_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Dump requested while an I access is outstanding.
    lat = 4;
    i_addr = 16'h0033; i_req = 1'b1;
    idone_cyc = -1; dump_cyc = -1; ddone_cyc = -1; ndump = 0;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      if (c == 2) dump_req = 1'b1;
      if (mif.mem_dump) begin
        ndump++;
        if (dump_cyc < 0) dump_cyc = c;
      end
      if (dump_done && ddone_cyc < 0) ddone_cyc = c;
      if (i_done && idone_cyc < 0) begin
        idone_cyc = c;
        chk("dumpwait_i_rdata", 32'(i_rdata), 32'h5A33);
        i_req = 1'b0;
      end
    end
    chk("dumpwait_i_done_cycle", idone_cyc, 6);
    chk("dumpwait_mem_dump_cycle", dump_cyc, 7);
    chk("dumpwait_dump_done_cycle", ddone_cyc, 8);
    chk("dumpwait_mem_dump_count", ndump, 1);
    d_addr = 16'h0040; d_req = 1'b1;
    nen = 0; nstall = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (mif.mem_en) nen++;
      if (d_stall) nstall++;
    end
    chk("halted_d_no_mem_en", nen, 0);
    chk("halted_d_stall_held", nstall, 10);
    d_req = 1'b0; dump_req = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
